// File: rtl/seq_divider_if.sv
// Operand/result bundle between the issuing core and the sequential divider.
// Requester owns start and operands; the divider owns busy, done and results.
interface seq_divider_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring divider, one quotient bit per clock, DIV/DIVU/REM/REMU results.
// Latency WIDTH+2 (2 for divide-by-zero and signed overflow); start is ignored while busy.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] quo_p;
    logic [WIDTH-1:0] rem_p;
    logic [WIDTH-1:0] div_p;
    logic [WIDTH-1:0] a_raw;
    logic [WIDTH-1:0] quo_o;
    logic [WIDTH-1:0] rem_o;
    logic             sign_q;
    logic             sign_r;
    logic             zero_q;
    logic             ovf_q;
    logic             busy_r;
    logic             done_r;
    logic             dz_r;

    logic             a_neg;
    logic             b_neg;
    logic             is_zero;
    logic             is_ovf;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   r_shift;
    logic             r_ge;
    logic [WIDTH-1:0] r_sub;

    always_comb begin
        a_neg   = bus.is_signed & bus.dividend[WIDTH-1];
        b_neg   = bus.is_signed & bus.divisor[WIDTH-1];
        a_mag   = a_neg ? -bus.dividend : bus.dividend;
        b_mag   = b_neg ? -bus.divisor : bus.divisor;
        is_zero = (bus.divisor == '0);
        is_ovf  = bus.is_signed && (bus.dividend == MIN_VAL) && (bus.divisor == '1);
        // Partial remainder kept one bit wider so divisors above 2^(WIDTH-1) stay exact.
        r_shift = {rem_p, quo_p[WIDTH-1]};
        r_ge    = (r_shift >= {1'b0, div_p});
        r_sub   = r_shift[WIDTH-1:0] - div_p;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            quo_p  <= '0;
            rem_p  <= '0;
            div_p  <= '0;
            a_raw  <= '0;
            quo_o  <= '0;
            rem_o  <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            dz_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // busy still set here means this is the done cycle: finish it, accept nothing.
                    if (busy_r) begin
                        busy_r <= 1'b0;
                        done_r <= 1'b0;
                    end else if (bus.start) begin
                        busy_r <= 1'b1;
                        dz_r   <= 1'b0;
                        quo_p  <= a_mag;
                        div_p  <= b_mag;
                        rem_p  <= '0;
                        a_raw  <= bus.dividend;
                        sign_q <= a_neg ^ b_neg;
                        sign_r <= a_neg;
                        zero_q <= is_zero;
                        ovf_q  <= is_ovf;
                        cnt    <= CW'(WIDTH);
                        state  <= (is_zero || is_ovf) ? FIX : RUN;
                    end
                end
                RUN: begin
                    rem_p <= r_ge ? r_sub : r_shift[WIDTH-1:0];
                    quo_p <= {quo_p[WIDTH-2:0], r_ge};
                    cnt   <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= FIX;
                end
                FIX: begin
                    done_r <= 1'b1;
                    state  <= IDLE;
                    if (zero_q) begin
                        quo_o <= '1;
                        rem_o <= a_raw;
                        dz_r  <= 1'b1;
                    end else if (ovf_q) begin
                        quo_o <= a_raw;
                        rem_o <= '0;
                    end else begin
                        quo_o <= sign_q ? -quo_p : quo_p;
                        rem_o <= sign_r ? -rem_p : rem_p;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.quotient    = quo_o;
    assign bus.remainder   = rem_o;
    assign bus.div_by_zero = dz_r;
endmodule

// File: tb/tb_seq_divider.sv
// Randomized and directed bench for seq_divider against an arithmetic reference model.
module tb_seq_divider;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    seq_divider_if #(.WIDTH(32)) bus ();
    seq_divider #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic void model(input bit s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output bit dz, output int lat);
        longint sa, sb;
        dz = 1'b0;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a; dz = 1'b1; lat = 2;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a; r = 32'd0; lat = 2;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q = 32'(sa / sb);
            r = 32'(sa % sb);
            lat = 34;
        end else begin
            q = a / b; r = a % b; lat = 34;
        end
    endfunction

    task automatic launch(input bit s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1; bus.is_signed = s; bus.dividend = a; bus.divisor = b;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Returns cycles from the accepting edge to the done cycle and busy-only cycle count.
    task automatic wait_done(output int lat, output int bcyc, output bit to);
        lat = 0; bcyc = 0; to = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            lat++;
            if (bus.done) begin
                to = 1'b0;
                break;
            end
            if (bus.busy) bcyc++;
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.is_signed = 1'b0; bus.dividend = '0; bus.divisor = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder} !== 67'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b dz=%b q=%h r=%h expected all zero",
                     bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_no_done: got done=%b busy=%b expected 0 0", bus.done, bus.busy);
            end
        end
    endtask

    task automatic test_unsigned();
        int lat, bcyc; bit to;
        launch(1'b0, 32'd100, 32'd7);
        wait_done(lat, bcyc, to);
        n_checks++;
        if (to !== 1'b0 || lat != 34) begin
            n_fail++; $display("FAIL unsigned_latency: got %0d (timeout=%b) expected 34", lat, to);
        end
        n_checks++;
        if (bcyc != 33 || bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL unsigned_busy: got %0d busy cycles, busy at done=%b expected 33, 1", bcyc, bus.busy);
        end
        n_checks++;
        if (bus.quotient !== 32'd14 || bus.remainder !== 32'd2 || bus.div_by_zero !== 1'b0) begin
            n_fail++; $display("FAIL unsigned_result: got q=%h r=%h dz=%b expected 0000000e 00000002 0",
                               bus.quotient, bus.remainder, bus.div_by_zero);
        end
        @(negedge clk);
        n_checks++;
        if (bus.done !== 1'b0 || bus.quotient !== 32'd14 || bus.remainder !== 32'd2) begin
            n_fail++; $display("FAIL done_pulse_hold: got done=%b q=%h r=%h expected 0 0000000e 00000002",
                               bus.done, bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_signed();
        int lat, bcyc; bit to;
        launch(1'b1, 32'hFFFF_FF9C, 32'd7);
        wait_done(lat, bcyc, to);
        n_checks++;
        if (to || bus.quotient !== 32'hFFFF_FFF2 || bus.remainder !== 32'hFFFF_FFFE) begin
            n_fail++; $display("FAIL signed_neg_dividend: got q=%h r=%h expected fffffff2 fffffffe",
                               bus.quotient, bus.remainder);
        end
        launch(1'b1, 32'd100, 32'hFFFF_FFF9);
        wait_done(lat, bcyc, to);
        n_checks++;
        if (to || bus.quotient !== 32'hFFFF_FFF2 || bus.remainder !== 32'd2) begin
            n_fail++; $display("FAIL signed_neg_divisor: got q=%h r=%h expected fffffff2 00000002",
                               bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_div_zero();
        int lat, bcyc; bit to;
        for (int s = 0; s < 2; s++) begin
            launch(s[0], 32'h1234_5678, 32'd0);
            wait_done(lat, bcyc, to);
            n_checks++;
            if (to || lat != 2) begin
                n_fail++; $display("FAIL div0_latency s=%0d: got %0d expected 2", s, lat);
            end
            n_checks++;
            if (bus.quotient !== 32'hFFFF_FFFF || bus.remainder !== 32'h1234_5678 || bus.div_by_zero !== 1'b1) begin
                n_fail++; $display("FAIL div0_result s=%0d: got q=%h r=%h dz=%b expected ffffffff 12345678 1",
                                   s, bus.quotient, bus.remainder, bus.div_by_zero);
            end
        end
    endtask

    task automatic test_overflow();
        launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        @(negedge clk);
        n_checks++;
        if (bus.div_by_zero !== 1'b0 || bus.quotient !== 32'hFFFF_FFFF || bus.done !== 1'b0) begin
            n_fail++; $display("FAIL accept_clears_dz: got dz=%b q=%h done=%b expected 0 ffffffff 0",
                               bus.div_by_zero, bus.quotient, bus.done);
        end
        @(negedge clk);
        n_checks++;
        if (bus.done !== 1'b1 || bus.quotient !== 32'h8000_0000 || bus.remainder !== 32'd0 || bus.div_by_zero !== 1'b0) begin
            n_fail++; $display("FAIL overflow_result: got done=%b q=%h r=%h dz=%b expected 1 80000000 00000000 0",
                               bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
        end
    endtask

    task automatic test_busy_guard();
        int dones = 0;
        logic [31:0] q_seen = '0, r_seen = '0;
        launch(1'b0, 32'd5, 32'd2);
        repeat (9) @(negedge clk);
        bus.start = 1'b1; bus.dividend = 32'd9; bus.divisor = 32'd3;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.done) begin
                dones++;
                q_seen = bus.quotient; r_seen = bus.remainder;
            end
        end
        n_checks++;
        if (dones != 1 || q_seen !== 32'd2 || r_seen !== 32'd1) begin
            n_fail++; $display("FAIL busy_guard: got %0d dones q=%h r=%h expected 1 00000002 00000001",
                               dones, q_seen, r_seen);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bcyc; bit to;
        launch(1'b0, 32'd100, 32'd7);
        wait_done(lat, bcyc, to);
        bus.start = 1'b1; bus.is_signed = 1'b0; bus.dividend = 32'd1000; bus.divisor = 32'd10;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (to || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++; $display("FAIL start_in_done_cycle: got busy=%b done=%b expected 0 0", bus.busy, bus.done);
        end
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(lat, bcyc, to);
        n_checks++;
        if (to || lat != 34 || bus.quotient !== 32'd100 || bus.remainder !== 32'd0) begin
            n_fail++; $display("FAIL back_to_back: got lat=%0d q=%h r=%h expected 34 00000064 00000000",
                               lat, bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat, bcyc, dones = 0; bit to;
        launch(1'b0, 32'hDEAD_BEEF, 32'd3);
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder} !== 67'd0) begin
            n_fail++; $display("FAIL reset_mid_op: got busy=%b done=%b dz=%b q=%h r=%h expected all zero",
                               bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        n_checks++;
        if (dones != 0) begin
            n_fail++; $display("FAIL abort_no_done: got %0d dones expected 0", dones);
        end
        launch(1'b0, 32'hFFFF_FFFF, 32'h10);
        wait_done(lat, bcyc, to);
        n_checks++;
        if (to || bus.quotient !== 32'h0FFF_FFFF || bus.remainder !== 32'hF) begin
            n_fail++; $display("FAIL post_reset_op: got q=%h r=%h expected 0fffffff 0000000f",
                               bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_random();
        int lat, bcyc, exp_lat; bit to, exp_dz, s;
        logic [31:0] a, b, exp_q, exp_r;
        for (int i = 0; i < 60; i++) begin
            s = bit'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin s = 1'b1; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 15);
                3: a = $urandom_range(0, 255);
                4: b = b | 32'h8000_0000;
                default: ;
            endcase
            model(s, a, b, exp_q, exp_r, exp_dz, exp_lat);
            launch(s, a, b);
            wait_done(lat, bcyc, to);
            n_checks++;
            if (to || lat != exp_lat) begin
                n_fail++; $display("FAIL rand_latency #%0d: got %0d (timeout=%b) expected %0d", i, lat, to, exp_lat);
            end
            n_checks++;
            if (bus.quotient !== exp_q || bus.remainder !== exp_r || bus.div_by_zero !== exp_dz) begin
                n_fail++; $display("FAIL rand_result #%0d s=%b %h/%h: got q=%h r=%h dz=%b expected %h %h %b",
                                   i, s, a, b, bus.quotient, bus.remainder, bus.div_by_zero, exp_q, exp_r, exp_dz);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_busy_guard();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
